ofs_plat_avalon_mem_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one Avalon memory sink between NUM_SOURCES Avalon memory sources, all on one clock. It sits between several AFU-side engines and a single, optionally pipelined, Avalon memory port. It locks the grant for the full length of a write burst and routes read data and write responses back to the issuing source through in-order tracking FIFOs.

---
 rtl/ofs_plat_avalon_mem_rr_arbiter.sv | 248 ++++++++++++++++++++++++
 tb/tb_ofs_plat_avalon_mem_rr_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_avalon_mem_rr_arbiter.sv
// rtl/ofs_plat_avalon_mem_rr_arbiter.sv - round-robin Avalon memory arbiter with write-burst lock
// Responses are steered back to their issuing source through in-order tracking FIFOs.
module ofs_plat_avalon_mem_rr_arbiter #(
    parameter int NUM_SOURCES     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int MAX_OUTSTANDING = 64
) (
    input  logic                                    clk,
    input  logic                                    reset_n,

    input  logic [NUM_SOURCES-1:0]                  src_read,
    input  logic [NUM_SOURCES-1:0]                  src_write,
    input  logic [NUM_SOURCES*ADDR_WIDTH-1:0]       src_address,
    input  logic [NUM_SOURCES*BURST_CNT_WIDTH-1:0]  src_burstcount,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0]       src_writedata,
    input  logic [NUM_SOURCES*DATA_WIDTH/8-1:0]     src_byteenable,
    output logic [NUM_SOURCES-1:0]                  src_waitrequest,
    output logic [DATA_WIDTH-1:0]                   src_readdata,
    output logic [NUM_SOURCES-1:0]                  src_readdatavalid,
    output logic [NUM_SOURCES-1:0]                  src_writeresponsevalid,

    output logic                                    sink_read,
    output logic                                    sink_write,
    output logic [ADDR_WIDTH-1:0]                   sink_address,
    output logic [BURST_CNT_WIDTH-1:0]              sink_burstcount,
    output logic [DATA_WIDTH-1:0]                   sink_writedata,
    output logic [DATA_WIDTH/8-1:0]                 sink_byteenable,
    input  logic                                    sink_waitrequest,
    input  logic [DATA_WIDTH-1:0]                   sink_readdata,
    input  logic                                    sink_readdatavalid,
    input  logic                                    sink_writeresponsevalid,

    output logic                                    error
);

    localparam int SRC_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE_ARB, HOLD, WR_LOCK} state_t;

    state_t                     state_q, state_d;
    logic [SRC_W-1:0]           grant_q, grant_d;
    logic [SRC_W-1:0]           last_grant, last_grant_d;
    logic [BURST_CNT_WIDTH-1:0] beats_left, beats_left_d;

    logic [ADDR_WIDTH-1:0]      addr_a [NUM_SOURCES];
    logic [BURST_CNT_WIDTH-1:0] bc_a   [NUM_SOURCES];
    logic [DATA_WIDTH-1:0]      wd_a   [NUM_SOURCES];
    logic [BE_W-1:0]            be_a   [NUM_SOURCES];

    logic [NUM_SOURCES-1:0]     req;
    logic [SRC_W-1:0]           winner, sel;
    logic                       found, sel_valid, sel_is_wr, accept;
    logic [BURST_CNT_WIDTH-1:0] sel_bc;

    // Read tracking FIFO: one entry per burst, {source, burstcount}
    logic [SRC_W-1:0]           rd_src_mem [MAX_OUTSTANDING];
    logic [BURST_CNT_WIDTH-1:0] rd_bc_mem  [MAX_OUTSTANDING];
    logic [PTR_W-1:0]           rd_wptr, rd_rptr;
    logic [CNT_W-1:0]           rd_count;
    logic [BURST_CNT_WIDTH-1:0] rd_beats_left, rd_cur_left;
    logic                       rd_push, rd_pop, rd_empty, rd_full_eff, rd_hit, rd_last;

    logic [SRC_W-1:0]           wr_src_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]           wr_wptr, wr_rptr;
    logic [CNT_W-1:0]           wr_count;
    logic                       wr_push, wr_pop, wr_empty, wr_full_eff;

    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            addr_a[i] = src_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            bc_a[i]   = src_burstcount[i*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];
            wd_a[i]   = src_writedata[i*DATA_WIDTH +: DATA_WIDTH];
            be_a[i]   = src_byteenable[i*BE_W +: BE_W];
        end
    end

    // A pop in the same cycle frees a slot, so fullness looks through it
    assign rd_empty    = (rd_count == '0);
    assign wr_empty    = (wr_count == '0);
    assign rd_full_eff = (rd_count == CNT_W'(MAX_OUTSTANDING)) && !rd_pop;
    assign wr_full_eff = (wr_count == CNT_W'(MAX_OUTSTANDING)) && !wr_pop;

    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            req[i] = src_write[i] ? !wr_full_eff : (src_read[i] && !rd_full_eff);
        end
    end

    always_comb begin
        int idx;
        logic [SRC_W-1:0] cand;
        idx    = 0;
        cand   = '0;
        winner = last_grant;
        found  = 1'b0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            idx  = (int'(last_grant) + 1 + k) % NUM_SOURCES;
            cand = SRC_W'(idx);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        sel       = grant_q;
        sel_valid = 1'b0;
        case (state_q)
            IDLE_ARB: begin
                sel       = winner;
                sel_valid = found;
            end
            HOLD:     sel_valid = req[grant_q];
            WR_LOCK:  sel_valid = src_write[grant_q];
            default:  sel_valid = 1'b0;
        endcase
        if (!reset_n) begin
            sel_valid = 1'b0;
        end
    end

    assign sel_is_wr       = src_write[sel];
    assign sel_bc          = bc_a[sel];
    assign accept          = sel_valid && !sink_waitrequest;
    assign sink_read       = sel_valid && !sel_is_wr;
    assign sink_write      = sel_valid && sel_is_wr;
    assign sink_address    = addr_a[sel];
    assign sink_burstcount = sel_bc;
    assign sink_writedata  = wd_a[sel];
    assign sink_byteenable = be_a[sel];

    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            src_waitrequest[i] = !(sel_valid && (sel == SRC_W'(i))) || sink_waitrequest;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant;
        beats_left_d = beats_left;
        case (state_q)
            IDLE_ARB, HOLD: begin
                if (!sel_valid) begin
                    state_d = IDLE_ARB;
                end else begin
                    grant_d = sel;
                    if (!accept) begin
                        state_d = HOLD;
                    end else begin
                        last_grant_d = sel;
                        if (sel_is_wr && (sel_bc > BURST_CNT_WIDTH'(1))) begin
                            state_d      = WR_LOCK;
                            beats_left_d = sel_bc - BURST_CNT_WIDTH'(1);
                        end else begin
                            state_d = IDLE_ARB;
                        end
                    end
                end
            end
            WR_LOCK: begin
                if (accept) begin
                    last_grant_d = sel;
                    beats_left_d = beats_left - BURST_CNT_WIDTH'(1);
                    if (beats_left <= BURST_CNT_WIDTH'(1)) begin
                        state_d = IDLE_ARB;
                    end
                end
            end
            default: state_d = IDLE_ARB;
        endcase
    end

    assign rd_push = accept && !sel_is_wr;
    assign wr_push = accept && sel_is_wr && (state_q != WR_LOCK);

    // Beat counter of the head read burst; zero means "not yet loaded from the FIFO head"
    assign rd_cur_left = (rd_beats_left == '0) ? rd_bc_mem[rd_rptr] : rd_beats_left;
    assign rd_last     = (rd_cur_left == BURST_CNT_WIDTH'(1));
    assign rd_hit      = sink_readdatavalid && !rd_empty;
    assign rd_pop      = rd_hit && rd_last;
    assign wr_pop      = sink_writeresponsevalid && !wr_empty;
    assign src_readdata = sink_readdata;

    always_comb begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
            src_readdatavalid[i]      = rd_hit && (rd_src_mem[rd_rptr] == SRC_W'(i));
            src_writeresponsevalid[i] = wr_pop && (wr_src_mem[wr_rptr] == SRC_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) begin
            rd_src_mem[rd_wptr] <= sel;
            rd_bc_mem[rd_wptr]  <= sel_bc;
        end
        if (wr_push) begin
            wr_src_mem[wr_wptr] <= sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE_ARB;
            grant_q       <= '0;
            last_grant    <= SRC_W'(NUM_SOURCES - 1);
            beats_left    <= '0;
            rd_wptr       <= '0;
            rd_rptr       <= '0;
            rd_count      <= '0;
            rd_beats_left <= '0;
            wr_wptr       <= '0;
            wr_rptr       <= '0;
            wr_count      <= '0;
            error         <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_grant <= last_grant_d;
            beats_left <= beats_left_d;

            if (rd_push) rd_wptr <= rd_wptr + PTR_W'(1);
            if (rd_pop)  rd_rptr <= rd_rptr + PTR_W'(1);
            if (rd_push && !rd_pop)      rd_count <= rd_count + CNT_W'(1);
            else if (!rd_push && rd_pop) rd_count <= rd_count - CNT_W'(1);
            if (rd_hit) begin
                rd_beats_left <= rd_last ? '0 : rd_cur_left - BURST_CNT_WIDTH'(1);
            end

            if (wr_push) wr_wptr <= wr_wptr + PTR_W'(1);
            if (wr_pop)  wr_rptr <= wr_rptr + PTR_W'(1);
            if (wr_push && !wr_pop)      wr_count <= wr_count + CNT_W'(1);
            else if (!wr_push && wr_pop) wr_count <= wr_count - CNT_W'(1);

            if ((sink_readdatavalid && rd_empty) || (sink_writeresponsevalid && wr_empty)) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ofs_plat_avalon_mem_rr_arbiter.sv
// tb/tb_ofs_plat_avalon_mem_rr_arbiter.sv - directed self-checking bench for the round-robin arbiter
module tb_ofs_plat_avalon_mem_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 512;
    localparam int BW = 7;

    localparam logic [AW-1:0] A0 = 32'h0000_1000;
    localparam logic [AW-1:0] A1 = 32'h0000_2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  reset_n;
    logic [N-1:0]          src_read, src_write;
    logic [N*AW-1:0]       src_address;
    logic [N*BW-1:0]       src_burstcount;
    logic [N*DW-1:0]       src_writedata;
    logic [N*DW/8-1:0]     src_byteenable;
    logic [N-1:0]          src_waitrequest;
    logic [DW-1:0]         src_readdata;
    logic [N-1:0]          src_readdatavalid;
    logic [N-1:0]          src_writeresponsevalid;
    logic                  sink_read, sink_write;
    logic [AW-1:0]         sink_address;
    logic [BW-1:0]         sink_burstcount;
    logic [DW-1:0]         sink_writedata;
    logic [DW/8-1:0]       sink_byteenable;
    logic                  sink_waitrequest;
    logic [DW-1:0]         sink_readdata;
    logic                  sink_readdatavalid;
    logic                  sink_writeresponsevalid;
    logic                  error;

    int checks = 0;
    int errors = 0;

    ofs_plat_avalon_mem_rr_arbiter dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .src_read               (src_read),
        .src_write              (src_write),
        .src_address            (src_address),
        .src_burstcount         (src_burstcount),
        .src_writedata          (src_writedata),
        .src_byteenable         (src_byteenable),
        .src_waitrequest        (src_waitrequest),
        .src_readdata           (src_readdata),
        .src_readdatavalid      (src_readdatavalid),
        .src_writeresponsevalid (src_writeresponsevalid),
        .sink_read              (sink_read),
        .sink_write             (sink_write),
        .sink_address           (sink_address),
        .sink_burstcount        (sink_burstcount),
        .sink_writedata         (sink_writedata),
        .sink_byteenable        (sink_byteenable),
        .sink_waitrequest       (sink_waitrequest),
        .sink_readdata          (sink_readdata),
        .sink_readdatavalid     (sink_readdatavalid),
        .sink_writeresponsevalid(sink_writeresponsevalid),
        .error                  (error)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        src_read = 2'b11;
        repeat (3) @(posedge clk);
        #5;
        checks++;
        if (sink_read !== 1'b0 || sink_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_sink_cmd got rd=%b wr=%b exp 0 0", sink_read, sink_write);
        end
        checks++;
        if (src_waitrequest !== 2'b11) begin
            errors++;
            $display("FAIL reset_waitrequest got %b exp 11", src_waitrequest);
        end
        checks++;
        if (error !== 1'b0 || src_readdatavalid !== 2'b00 || src_writeresponsevalid !== 2'b00) begin
            errors++;
            $display("FAIL reset_valids got err=%b rdv=%b wrv=%b exp 0 00 00",
                     error, src_readdatavalid, src_writeresponsevalid);
        end
        tick;
        src_read = 2'b00;
        reset_n  = 1'b1;
    endtask

    task automatic test_rr_reads;
        logic [N-1:0]  exp_v [3];
        logic [AW-1:0] exp_a [3];
        exp_v[0] = 2'b01; exp_v[1] = 2'b10; exp_v[2] = 2'b01;
        exp_a[0] = A0;    exp_a[1] = A1;    exp_a[2] = A0;
        for (int c = 0; c < 3; c++) begin
            tick;
            src_read = 2'b11;
            #4;
            checks++;
            if (sink_read !== 1'b1 || sink_address !== exp_a[c] || src_waitrequest !== ~exp_v[c]) begin
                errors++;
                $display("FAIL rr_grant%0d got rd=%b addr=%h wait=%b exp 1 %h %b",
                         c, sink_read, sink_address, src_waitrequest, exp_a[c], ~exp_v[c]);
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            src_read = 2'b00;
            sink_readdatavalid = 1'b1;
            sink_readdata = DW'(c + 32'hA0);
            #4;
            checks++;
            if (src_readdatavalid !== exp_v[c] || src_readdata !== DW'(c + 32'hA0)) begin
                errors++;
                $display("FAIL rr_return%0d got %b exp %b", c, src_readdatavalid, exp_v[c]);
            end
        end
        tick;
        sink_readdatavalid = 1'b0;
    endtask

    task automatic test_write_lock;
        for (int b = 0; b < 4; b++) begin
            tick;
            if (b == 0) begin
                src_write = 2'b10;
                src_burstcount = {7'd4, 7'd1};
                src_read = 2'b01;
            end
            #4;
            checks++;
            if (sink_write !== 1'b1 || sink_read !== 1'b0 || sink_address !== A1 || src_waitrequest !== 2'b01) begin
                errors++;
                $display("FAIL wr_lock_beat%0d got wr=%b rd=%b addr=%h wait=%b exp 1 0 %h 01",
                         b, sink_write, sink_read, sink_address, src_waitrequest, A1);
            end
        end
        tick;
        src_write = 2'b00;
        #4;
        checks++;
        if (sink_read !== 1'b1 || sink_address !== A0 || src_waitrequest !== 2'b10) begin
            errors++;
            $display("FAIL wr_lock_after got rd=%b addr=%h wait=%b exp 1 %h 10",
                     sink_read, sink_address, src_waitrequest, A0);
        end
        tick;
        src_read = 2'b00;
        sink_writeresponsevalid = 1'b1;
        #4;
        checks++;
        if (src_writeresponsevalid !== 2'b10) begin
            errors++;
            $display("FAIL wr_lock_resp got %b exp 10", src_writeresponsevalid);
        end
        tick;
        sink_writeresponsevalid = 1'b0;
        sink_readdatavalid = 1'b1;
        #4;
        checks++;
        if (src_readdatavalid !== 2'b01) begin
            errors++;
            $display("FAIL wr_lock_rdret got %b exp 01", src_readdatavalid);
        end
        tick;
        sink_readdatavalid = 1'b0;
        src_burstcount = {7'd1, 7'd1};
    endtask

    task automatic test_hold;
        tick;
        src_read = 2'b01;
        sink_waitrequest = 1'b1;
        #4;
        checks++;
        if (sink_address !== A0 || src_waitrequest !== 2'b11) begin
            errors++;
            $display("FAIL hold_first got addr=%h wait=%b exp %h 11", sink_address, src_waitrequest, A0);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            src_read = 2'b11;
            #4;
            checks++;
            if (sink_read !== 1'b1 || sink_address !== A0 || src_waitrequest !== 2'b11) begin
                errors++;
                $display("FAIL hold_stall%0d got rd=%b addr=%h wait=%b exp 1 %h 11",
                         c, sink_read, sink_address, src_waitrequest, A0);
            end
        end
        tick;
        sink_waitrequest = 1'b0;
        #4;
        checks++;
        if (sink_address !== A0 || src_waitrequest !== 2'b10) begin
            errors++;
            $display("FAIL hold_accept got addr=%h wait=%b exp %h 10", sink_address, src_waitrequest, A0);
        end
        tick;
        src_read = 2'b10;
        #4;
        checks++;
        if (sink_address !== A1 || src_waitrequest !== 2'b01) begin
            errors++;
            $display("FAIL hold_next got addr=%h wait=%b exp %h 01", sink_address, src_waitrequest, A1);
        end
        tick;
        src_read = 2'b00;
        sink_readdatavalid = 1'b1;
        #4;
        checks++;
        if (src_readdatavalid !== 2'b01) begin
            errors++;
            $display("FAIL hold_ret0 got %b exp 01", src_readdatavalid);
        end
        tick;
        #4;
        checks++;
        if (src_readdatavalid !== 2'b10) begin
            errors++;
            $display("FAIL hold_ret1 got %b exp 10", src_readdatavalid);
        end
        tick;
        sink_readdatavalid = 1'b0;
    endtask

    task automatic test_fifo_full;
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            tick;
            if (i == 0) src_read = 2'b01;
            #4;
            if (src_waitrequest[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_fill stalled=%0d exp 0", bad);
        end
        tick;
        src_write = 2'b10;
        #4;
        checks++;
        if (src_waitrequest !== 2'b01 || sink_write !== 1'b1 || sink_read !== 1'b0 || sink_address !== A1) begin
            errors++;
            $display("FAIL full_block got wait=%b wr=%b rd=%b addr=%h exp 01 1 0 %h",
                     src_waitrequest, sink_write, sink_read, sink_address, A1);
        end
        tick;
        src_write = 2'b00;
        sink_readdatavalid = 1'b1;
        #4;
        checks++;
        if (src_readdatavalid !== 2'b01 || src_waitrequest !== 2'b10 || sink_read !== 1'b1) begin
            errors++;
            $display("FAIL full_free got rdv=%b wait=%b rd=%b exp 01 10 1",
                     src_readdatavalid, src_waitrequest, sink_read);
        end
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            tick;
            if (i == 0) src_read = 2'b00;
            #4;
            if (src_readdatavalid !== 2'b01) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL full_drain wrong=%0d exp 0", bad);
        end
        tick;
        sink_readdatavalid = 1'b0;
        sink_writeresponsevalid = 1'b1;
        #4;
        checks++;
        if (src_writeresponsevalid !== 2'b10) begin
            errors++;
            $display("FAIL full_wresp got %b exp 10", src_writeresponsevalid);
        end
        tick;
        sink_writeresponsevalid = 1'b0;
        #4;
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL full_noerr got %b exp 0", error);
        end
    endtask

    task automatic test_error;
        tick;
        sink_readdatavalid = 1'b1;
        #4;
        checks++;
        if (src_readdatavalid !== 2'b00) begin
            errors++;
            $display("FAIL err_valid got %b exp 00", src_readdatavalid);
        end
        tick;
        sink_readdatavalid = 1'b0;
        #4;
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL err_set got %b exp 1", error);
        end
        repeat (3) tick;
        #4;
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got %b exp 1", error);
        end
    endtask

    task automatic test_reset_mid_burst;
        tick;
        src_write = 2'b10;
        src_burstcount = {7'd8, 7'd1};
        #4;
        checks++;
        if (sink_write !== 1'b1 || sink_address !== A1) begin
            errors++;
            $display("FAIL rst_burst_start got wr=%b addr=%h exp 1 %h", sink_write, sink_address, A1);
        end
        tick;
        reset_n = 1'b0;
        #4;
        checks++;
        if (sink_write !== 1'b0 || src_waitrequest !== 2'b11 || error !== 1'b0) begin
            errors++;
            $display("FAIL rst_burst_cut got wr=%b wait=%b err=%b exp 0 11 0",
                     sink_write, src_waitrequest, error);
        end
        tick;
        src_write = 2'b00;
        src_burstcount = {7'd1, 7'd1};
        tick;
        reset_n = 1'b1;
        sink_writeresponsevalid = 1'b1;
        #4;
        checks++;
        if (src_writeresponsevalid !== 2'b00 || sink_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_wresp got wrv=%b wr=%b exp 00 0", src_writeresponsevalid, sink_write);
        end
        tick;
        sink_writeresponsevalid = 1'b0;
        src_read = 2'b11;
        #4;
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL rst_late_err got %b exp 1", error);
        end
        checks++;
        if (sink_address !== A0 || src_waitrequest !== 2'b10) begin
            errors++;
            $display("FAIL rst_priority got addr=%h wait=%b exp %h 10", sink_address, src_waitrequest, A0);
        end
        tick;
        src_read = 2'b00;
    endtask

    initial begin
        reset_n = 1'b0;
        src_read = '0;
        src_write = '0;
        src_address = {A1, A0};
        src_burstcount = {7'd1, 7'd1};
        src_writedata = '0;
        src_byteenable = '1;
        sink_waitrequest = 1'b0;
        sink_readdata = '0;
        sink_readdatavalid = 1'b0;
        sink_writeresponsevalid = 1'b0;

        test_reset;
        test_rr_reads;
        test_write_lock;
        test_hold;
        test_fifo_full;
        test_error;
        test_reset_mid_burst;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
